// File: rtl/accelerator_vector_streamer.sv
// Operand feeder for the dot-product stage: buffers vectors A and B, then
// streams (A[i], B[i]) pairs one per consumer request with a one-cycle strobe.
module accelerator_vector_streamer #(
  parameter int DATA_SIZE    = 64,
  parameter int ADDRESS_SIZE = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WRITE_A_ENABLE,
  input  logic                  WRITE_B_ENABLE,
  input  logic [DATA_SIZE-1:0]  WRITE_DATA,
  output logic [ADDRESS_SIZE:0] COUNT_A,
  output logic [ADDRESS_SIZE:0] COUNT_B,
  input  logic                  START,
  input  logic [DATA_SIZE-1:0]  LENGTH_IN,
  output logic                  READY,
  output logic                  ERROR,
  input  logic                  NEXT,
  output logic [DATA_SIZE-1:0]  DATA_A_OUT,
  output logic [DATA_SIZE-1:0]  DATA_B_OUT,
  output logic                  DATA_OUT_ENABLE,
  output logic                  LAST
);
  localparam int DEPTH = 2 ** ADDRESS_SIZE;
  localparam int CW    = ADDRESS_SIZE + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_NEXT, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       count_a_q, count_a_d, count_b_q, count_b_d;
  logic [CW-1:0]       index_q, index_d, length_q, length_d;
  logic [DATA_SIZE-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
  logic                enable_q, enable_d, last_q, last_d;
  logic                ready_q, ready_d, error_q, error_d;

  logic [DATA_SIZE-1:0] mem_a [DEPTH];
  logic [DATA_SIZE-1:0] mem_b [DEPTH];
  logic                 wr_a, wr_b;
  logic [CW-1:0]        min_cnt;
  logic                 len_ok;

  // The full 64-bit length is compared so stray upper bits cause a reject.
  always_comb begin
    min_cnt = (count_a_q < count_b_q) ? count_a_q : count_b_q;
    len_ok  = (LENGTH_IN != '0) && (LENGTH_IN <= DATA_SIZE'(min_cnt));
  end

  // Next-state and registered-output computation for the streaming FSM.
  always_comb begin
    state_d   = state_q;
    count_a_d = count_a_q;
    count_b_d = count_b_q;
    index_d   = index_q;
    length_d  = length_q;
    data_a_d  = data_a_q;
    data_b_d  = data_b_q;
    enable_d  = 1'b0;
    last_d    = 1'b0;
    ready_d   = 1'b0;
    error_d   = 1'b0;
    wr_a      = 1'b0;
    wr_b      = 1'b0;
    case (state_q)
      IDLE: begin
        if (START && len_ok) begin
          length_d = LENGTH_IN[CW-1:0];
          index_d  = '0;
          state_d  = ISSUE;
        end else begin
          if (START) begin
            ready_d = 1'b1;
            error_d = 1'b1;
          end
          if (WRITE_A_ENABLE && (count_a_q < CW'(DEPTH))) begin
            wr_a      = 1'b1;
            count_a_d = count_a_q + CW'(1);
          end
          if (WRITE_B_ENABLE && (count_b_q < CW'(DEPTH))) begin
            wr_b      = 1'b1;
            count_b_d = count_b_q + CW'(1);
          end
        end
      end
      ISSUE: begin
        data_a_d = mem_a[index_q[ADDRESS_SIZE-1:0]];
        data_b_d = mem_b[index_q[ADDRESS_SIZE-1:0]];
        enable_d = 1'b1;
        last_d   = (index_q == length_q - CW'(1));
        state_d  = WAIT_NEXT;
      end
      WAIT_NEXT: begin
        // A request that overlaps the strobe cycle is not a new request.
        if (NEXT && !enable_q) begin
          if (index_q == length_q - CW'(1)) begin
            ready_d   = 1'b1;
            count_a_d = '0;
            count_b_d = '0;
            state_d   = DONE;
          end else begin
            index_d = index_q + CW'(1);
            state_d = ISSUE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset wins over everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      count_a_q <= '0;
      count_b_q <= '0;
      index_q   <= '0;
      length_q  <= '0;
      data_a_q  <= '0;
      data_b_q  <= '0;
      enable_q  <= 1'b0;
      last_q    <= 1'b0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_a_q <= count_a_d;
      count_b_q <= count_b_d;
      index_q   <= index_d;
      length_q  <= length_d;
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
      enable_q  <= enable_d;
      last_q    <= last_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
    end
  end

  // Operand storage; contents survive reset, only the counts are cleared.
  always_ff @(posedge CLK) begin
    if (!RST && wr_a) mem_a[count_a_q[ADDRESS_SIZE-1:0]] <= WRITE_DATA;
    if (!RST && wr_b) mem_b[count_b_q[ADDRESS_SIZE-1:0]] <= WRITE_DATA;
  end

  assign COUNT_A         = count_a_q;
  assign COUNT_B         = count_b_q;
  assign DATA_A_OUT      = data_a_q;
  assign DATA_B_OUT      = data_b_q;
  assign DATA_OUT_ENABLE = enable_q;
  assign LAST            = last_q;
  assign READY           = ready_q;
  assign ERROR           = error_q;
endmodule
